vga_timing_monitor: RTL

Synthesizable VGA sink on the TinyVGA PMOD pinout; the receiving end of the tt_um_embeddedinn_vga output bus.
- Recovers line and frame structure from the `uo_out` byte.
- Measures sync widths and periods, checks them against parameterised 640x480 timing, and computes a per-frame pixel checksum.
- Used in-bench and in on-FPGA loopback to prove the generator end to end.

---
 rtl/vga_timing_monitor_if.sv | 33 +++
 rtl/vga_timing_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_monitor_if
// Purpose  : TinyVGA input byte, control and measurement results of the monitor
// Revision : 1.0
// ============================================================================
interface vga_timing_monitor_if;
    logic        ena;
    logic [7:0]  vga_in;
    logic        clr_err;
    logic [10:0] line_len;
    logic [10:0] hsync_w;
    logic [10:0] frame_lines;
    logic [10:0] vsync_w;
    logic [15:0] frame_sum;
    logic        frame_done;
    logic        err_h;
    logic        err_v;
    logic        locked;

    modport master (
        output ena, vga_in, clr_err,
        input  line_len, hsync_w, frame_lines, vsync_w, frame_sum,
        input  frame_done, err_h, err_v, locked
    );

    modport slave (
        input  ena, vga_in, clr_err,
        output line_len, hsync_w, frame_lines, vsync_w, frame_sum,
        output frame_done, err_h, err_v, locked
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_monitor
// Purpose  : VGA sink: measures sync timing, checks it, and checksums frames
// Revision : 1.0
// ============================================================================
module vga_timing_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480,
    parameter int SYNC_NEG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_monitor_if.slave  bus
);
    localparam logic        POL   = (SYNC_NEG != 0);
    localparam logic [7:0]  IDLE  = POL ? 8'h88 : 8'h00;
    localparam logic [10:0] HT    = 11'(H_TOTAL);
    localparam logic [10:0] HS    = 11'(H_SYNC);
    localparam logic [10:0] VT    = 11'(V_TOTAL);
    localparam logic [10:0] VS    = 11'(V_SYNC);
    localparam logic [10:0] HA_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HA_HI = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [10:0] VA_LO = 11'(V_SYNC + V_BP);
    localparam logic [10:0] VA_HI = 11'(V_SYNC + V_BP + V_ACTIVE - 1);

    function automatic logic [10:0] sat_inc(input logic [10:0] v, input logic inc);
        return (inc && (v != 11'h7FF)) ? v + 11'd1 : v;
    endfunction

    logic [7:0]  s0, s1;
    logic [10:0] hcnt, hwc, vcnt, vwc;
    logic        h_valid, h_chk, v_valid, v_chk;
    logic [15:0] acc;
    logic        frame_bad;
    logic [1:0]  good_cnt;
    logic [10:0] line_len, hsync_w, frame_lines, vsync_w;
    logic [15:0] frame_sum;
    logic        frame_done, err_h, err_v;

    // Syncs normalised so that 1 always means asserted
    logic hs0, hs1, vs0, vs1;
    assign hs0 = s0[7] ^ POL;
    assign hs1 = s1[7] ^ POL;
    assign vs0 = s0[3] ^ POL;
    assign vs1 = s1[3] ^ POL;

    logic hs_lead, hs_trail, vs_lead, vs_trail;
    assign hs_lead  = bus.ena &  hs0 & ~hs1;
    assign hs_trail = bus.ena & ~hs0 &  hs1;
    assign vs_lead  = bus.ena &  vs0 & ~vs1;
    assign vs_trail = bus.ena & ~vs0 &  vs1;

    logic [10:0] hcnt_inc, vcnt_inc;
    assign hcnt_inc = sat_inc(hcnt, 1'b1);
    assign vcnt_inc = sat_inc(vcnt, hs_lead);

    logic h_bad, v_bad, bad_now, frame_evt;
    assign h_bad     = (hs_lead & h_valid & (hcnt_inc != HT)) | (hs_trail & h_chk & (hwc != HS));
    assign v_bad     = (vs_lead & v_valid & (vcnt_inc != VT)) | (vs_trail & v_chk & (vwc != VS));
    assign bad_now   = h_bad | v_bad;
    assign frame_evt = vs_lead & v_valid;

    // hcnt/vcnt line up with the pixel held in s1, not the newest sample
    logic       active;
    logic [5:0] pix;
    assign active = (hcnt >= HA_LO) && (hcnt <= HA_HI) && (vcnt >= VA_LO) && (vcnt <= VA_HI);
    assign pix    = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0          <= IDLE;
            s1          <= IDLE;
            hcnt        <= '0;
            hwc         <= '0;
            vcnt        <= '0;
            vwc         <= '0;
            h_valid     <= 1'b0;
            h_chk       <= 1'b0;
            v_valid     <= 1'b0;
            v_chk       <= 1'b0;
            acc         <= '0;
            frame_bad   <= 1'b0;
            good_cnt    <= '0;
            line_len    <= '0;
            hsync_w     <= '0;
            frame_lines <= '0;
            vsync_w     <= '0;
            frame_sum   <= '0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
        end else if (bus.ena) begin
            s0   <= bus.vga_in;
            s1   <= s0;
            hcnt <= hs_lead ? 11'd0 : hcnt_inc;
            hwc  <= hs0 ? sat_inc(hwc, 1'b1) : 11'd0;
            if (hs_lead) begin
                h_valid <= 1'b1;
                h_chk   <= h_valid;
                if (h_valid) line_len <= hcnt_inc;
            end
            if (hs_trail) hsync_w <= hwc;

            vcnt <= vs_lead ? 11'd0 : vcnt_inc;
            vwc  <= vs0 ? sat_inc(vwc, hs_lead) : 11'd0;
            if (vs_lead) begin
                v_valid <= 1'b1;
                v_chk   <= v_valid;
            end
            if (frame_evt) begin
                frame_lines <= vcnt_inc;
                frame_sum   <= acc;
            end
            if (vs_trail) vsync_w <= vwc;

            acc <= vs_lead ? 16'd0 : acc + (active ? {10'd0, pix} : 16'd0);

            if (h_bad)            err_h <= 1'b1;
            else if (bus.clr_err) err_h <= 1'b0;
            if (v_bad)            err_v <= 1'b1;
            else if (bus.clr_err) err_v <= 1'b0;

            // A mismatch drops lock at once; otherwise a frame boundary grades the frame
            if (bad_now)        good_cnt <= 2'd0;
            else if (frame_evt) good_cnt <= frame_bad ? 2'd0 :
                                            (good_cnt == 2'd3) ? good_cnt : good_cnt + 2'd1;
            frame_bad <= frame_evt ? 1'b0 : (frame_bad | bad_now);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= frame_evt;
    end

    assign bus.line_len    = line_len;
    assign bus.hsync_w     = hsync_w;
    assign bus.frame_lines = frame_lines;
    assign bus.vsync_w     = vsync_w;
    assign bus.frame_sum   = frame_sum;
    assign bus.frame_done  = frame_done;
    assign bus.err_h       = err_h;
    assign bus.err_v       = err_v;
    assign bus.locked      = (good_cnt >= 2'd2);
endmodule
`default_nettype wire
